// File: rtl/rr_encoder_pkg.sv
// Shared constants and state encoding for the round-robin 16-to-4 encoder.
package rr_encoder_pkg;

  localparam int unsigned N     = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping to 0.
module rr_pick
  import rr_encoder_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] low;

  // Doubling the vector turns a plain right shift into a rotate.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N-1:0];

  always_comb begin
    low = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) low = IDX_W'(i);
    end
  end

  // Index arithmetic is modulo 16 by width.
  assign idx   = low + ptr;
  assign any   = |req;
  assign multi = |(req & (req - N'(1)));

endmodule

// File: rtl/rr_encoder16.sv
// Round-robin 16-to-4 encoder with valid/ack handshake; all outputs are flops.
module rr_encoder16
  import rr_encoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N-1:0]     req,
  input  logic             ack,
  output logic [IDX_W-1:0] binary_out,
  output logic             valid,
  output logic             multi
);

  state_e           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             pick_multi;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .any   (pick_any),
    .multi (pick_multi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      binary_out <= '0;
      valid      <= 1'b0;
      multi      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable && pick_any) begin
            binary_out <= pick_idx;
            multi      <= pick_multi;
            valid      <= 1'b1;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          // req and enable are ignored here; the grant is held until ack.
          if (ack) begin
            valid   <= 1'b0;
            ptr_q   <= binary_out + IDX_W'(1);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_encoder16.sv
// Self-checking bench for rr_encoder16: grant vectors, tied-ack fairness, hold and reset cases.
module tb_rr_encoder16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable;
  logic [15:0] req;
  logic        ack;
  logic [3:0]  binary_out;
  logic        valid;
  logic        multi;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] idx;
    logic       multi;
  } exp_t;

  typedef struct {
    logic [15:0] req;
    logic [3:0]  idx;
    logic        multi;
    int          hold;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  bit   valid_seen = 1'b0;
  vec_t vecs[11];

  rr_encoder16 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .req        (req),
    .ack        (ack),
    .binary_out (binary_out),
    .valid      (valid),
    .multi      (multi)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] model_pick(input logic [15:0] r, input logic [3:0] p);
    for (int k = 0; k < 16; k++) begin
      logic [3:0] j;
      j = p + 4'(k);
      if (r[j]) return j;
    end
    return 4'd0;
  endfunction

  // Scoreboard: every new grant (rising valid) must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (valid === 1'b1 && !valid_seen) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected grant: got idx %0d expected no grant", binary_out);
      end else begin
        mon_e = sb_q.pop_front();
        check("grant idx", 32'(binary_out), 32'(mon_e.idx));
        check("grant multi", 32'(multi), 32'(mon_e.multi));
      end
    end
    valid_seen = (valid === 1'b1);
  end

  // Called at a negedge with the DUT idle; grant must appear after one edge.
  task automatic drive_grant(input logic [15:0] r, input logic [3:0] idx, input logic m,
                             input int hold);
    req    = r;
    enable = 1'b1;
    sb_q.push_back('{idx: idx, multi: m});
    @(negedge clk);
    check("grant latency valid", 32'(valid), 32'd1);
    enable = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold valid", 32'(valid), 32'd1);
      check("hold idx", 32'(binary_out), 32'(idx));
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ack drops valid", 32'(valid), 32'd0);
    check("idx kept after ack", 32'(binary_out), 32'(idx));
  endtask

  task automatic run_tied(input logic [15:0] r, input int n, input logic [3:0] start_ptr);
    logic [3:0] p;
    logic [3:0] g;
    p = start_ptr;
    for (int k = 0; k < n; k++) begin
      g = model_pick(r, p);
      sb_q.push_back('{idx: g, multi: ($countones(r) > 1)});
      p = g + 4'd1;
    end
    req    = r;
    enable = 1'b1;
    ack    = 1'b1;
    for (int i = 0; i < 2 * n; i++) begin
      @(negedge clk);
      check("tied valid toggle", 32'(valid), 32'((i % 2) == 0));
      if (i == 2 * n - 2) enable = 1'b0;
    end
    ack = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{16'h0300, 4'd9,  1'b1, 0};
    vecs[1]  = '{16'h0001, 4'd0,  1'b0, 1};
    vecs[2]  = '{16'h0003, 4'd1,  1'b1, 0};
    vecs[3]  = '{16'h0003, 4'd0,  1'b1, 0};
    vecs[4]  = '{16'h8000, 4'd15, 1'b0, 1};
    vecs[5]  = '{16'h00F0, 4'd4,  1'b1, 0};
    vecs[6]  = '{16'h0030, 4'd5,  1'b1, 0};
    vecs[7]  = '{16'h0030, 4'd4,  1'b1, 2};
    vecs[8]  = '{16'hA000, 4'd13, 1'b1, 0};
    vecs[9]  = '{16'h2001, 4'd0,  1'b1, 0};
    vecs[10] = '{16'h8000, 4'd15, 1'b0, 0};

    enable = 1'b1;
    req    = 16'hFFFF;
    ack    = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset valid", 32'(valid), 32'd0);
    check("reset binary_out", 32'(binary_out), 32'd0);
    check("reset multi", 32'(multi), 32'd0);
    check("reset ptr", 32'(dut.ptr_q), 32'd0);

    // First grant straight out of reset.
    rst_n = 1'b1;
    sb_q.push_back('{idx: 4'd0, multi: 1'b1});
    @(negedge clk);
    check("post-reset valid", 32'(valid), 32'd1);
    enable = 1'b0;
    ack    = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("post-reset ack", 32'(valid), 32'd0);

    // Single request, valid high for exactly three cycles.
    drive_grant(16'h0100, 4'd8, 1'b0, 2);
    check("ptr after idx 8", 32'(dut.ptr_q), 32'd9);

    for (int v = 0; v < 11; v++) begin
      drive_grant(vecs[v].req, vecs[v].idx, vecs[v].multi, vecs[v].hold);
    end
    check("ptr after table", 32'(dut.ptr_q), 32'd0);

    run_tied(16'h8001, 6, 4'd0);
    run_tied(16'hFFFF, 17, 4'd0);
    check("ptr after fairness", 32'(dut.ptr_q), 32'd1);

    // Grant at 3 must hold while req and enable change.
    req    = 16'h0008;
    enable = 1'b1;
    sb_q.push_back('{idx: 4'd3, multi: 1'b0});
    @(negedge clk);
    check("hold grant valid", 32'(valid), 32'd1);
    req    = 16'h0000;
    enable = 1'b0;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      check("ignore valid", 32'(valid), 32'd1);
      check("ignore idx", 32'(binary_out), 32'd3);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ignore ack", 32'(valid), 32'd0);

    // ack while idle must neither grant nor move ptr.
    enable = 1'b1;
    req    = 16'h0000;
    for (int h = 0; h < 3; h++) begin
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      @(negedge clk);
      check("idle ack valid", 32'(valid), 32'd0);
    end
    check("idle ack ptr", 32'(dut.ptr_q), 32'd4);
    drive_grant(16'h0011, 4'd4, 1'b1, 0);

    // Asynchronous reset in the middle of a grant.
    req    = 16'h0040;
    enable = 1'b1;
    sb_q.push_back('{idx: 4'd6, multi: 1'b0});
    @(negedge clk);
    check("pre-reset grant valid", 32'(valid), 32'd1);
    enable = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async reset valid", 32'(valid), 32'd0);
    check("async reset idx", 32'(binary_out), 32'd0);
    check("async reset ptr", 32'(dut.ptr_q), 32'd0);
    req    = 16'h0004;
    enable = 1'b1;
    @(negedge clk);
    check("in reset valid", 32'(valid), 32'd0);
    rst_n = 1'b1;
    sb_q.push_back('{idx: 4'd2, multi: 1'b0});
    @(negedge clk);
    check("after reset grant valid", 32'(valid), 32'd1);
    enable = 1'b0;
    ack    = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("after reset ack", 32'(valid), 32'd0);

    repeat (2) @(negedge clk);
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_encoder16.md
# rr_encoder16

Round-robin 16-to-4 encoder: the inverse of the team's 4-to-16 one-hot decoder. It samples a 16-bit request vector, picks one set bit by rotating priority, and presents its binary index with a valid/ack handshake. It sits between request sources (or a decoder's output bus) and any consumer that needs a 4-bit index, such as a mux select or an arbiter grant.

## Interface
- N, 16, request vector width; only 16 is supported.
- IDX_W, 4, index width, equal to log2(N); fixed by N.

- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  when 1, requests may be sampled in IDLE.
- req  in  16  request vector; any number of bits may be set.
- ack  in  1  consumer accepts the presented index.
- binary_out  out  4  index of the granted request bit.
- valid  out  1  binary_out holds a grant awaiting ack.
- multi  out  1  more than one req bit was set when the grant was taken.

Reset is asynchronous and active-low on rst_n, with one clock, clk. While rst_n=0, outputs are binary_out=0, valid=0, multi=0, and internal state is state=IDLE, ptr=0.

## Operation
- Two-state FSM: IDLE and GRANT.
- IDLE:
  - If enable=1 and req!=0 at a clk edge, select the first set bit at index ≥ ptr, scanning upward.
  - If none is found, wrap and scan 0..ptr-1.
  - Register the result: binary_out=index, valid=1, multi=(popcount(req)>1). Next state is GRANT.
  - Otherwise stay in IDLE; outputs keep their last value with valid=0.
- GRANT:
  - binary_out and multi are frozen. Changes on req and enable are ignored.
  - On an edge with ack=1: valid←0, ptr←binary_out+1 modulo 16 (15 wraps to 0). Next state is IDLE.
  - With ack=0, remain in GRANT indefinitely.
- ack in IDLE is ignored and has no effect on ptr.
- Deasserting enable in GRANT does not abort the grant; it only blocks the next sample.
- A req bit that drops before ack does not cancel the grant; the consumer owns the staleness check.
- Fairness: with req=16'hFFFF held, successive grants are 0,1,2,…,15,0.
- Reset mid-GRANT: valid drops immediately (asynchronously), ptr returns to 0, and the pending grant is lost.

## Timing
- req is sampled at edge k; valid=1 and binary_out are visible after edge k (1-cycle latency).
- An ack sampled at edge m forces valid=0 after edge m.
- The earliest next grant is at edge m+1, giving one idle bubble cycle between grants. Maximum throughput is one grant per 2 cycles with ack tied high.
- valid, binary_out, and multi are all direct flop outputs; there is no combinational path from inputs to outputs.
- binary_out keeps the last granted index after ack, until the next grant or reset.

## Structure
- Package rr_encoder_pkg holds:
  - N=16 and IDX_W=4.
  - The state encoding: IDLE=1'b0, GRANT=1'b1.
- One combinational sub-module, rr_pick:
  - Inputs: req[15:0] and ptr[3:0].
  - Outputs: idx[3:0], any (meaning req!=0), and multi.
  - Implementation: rotate req right by ptr, find the lowest set bit, then add ptr back modulo 16.
- The top level contains the FSM, the ptr register, and the output registers only.

## Test plan
- Reset: hold rst_n=0 with req=16'hFFFF and enable=1. Expect valid=0, binary_out=0, multi=0. Release reset, then sample: grant index 0, multi=1.
- Single request: req=16'h0100, enable=1, ack pulsed 3 cycles after valid. Expect binary_out=8, multi=0, valid high for exactly 3 cycles, ptr then 9.
- Rotation and wrap: req=16'h8001, ack tied 1, six grants. Expect the index sequence 0,15,0,15,0,15, with valid toggling 1,0,1,0.
- Full fairness: req=16'hFFFF, ack tied 1. Expect 0..15 in order, then 0, with each grant 2 cycles apart.
- Hold and ignore:
  - In GRANT at index 3, change req to 16'h0000 and drop enable. Expect binary_out stays 3 and valid stays 1 until ack.
  - ack pulses during IDLE produce no grant and leave ptr unchanged.
- Async reset mid-GRANT: assert rst_n=0 between clock edges while valid=1. Expect valid=0 immediately and ptr=0. After release with req=16'h0004, the grant index is 2.
